// File: rtl/uart_pkg.sv
// Shared register map, bit positions and TX launch FSM states for the APB UART front-end.
package uart_pkg;

  // Byte offsets of the register map
  localparam int unsigned REG_CTRL    = 'h00;
  localparam int unsigned REG_STATUS  = 'h04;
  localparam int unsigned REG_TXDATA  = 'h08;
  localparam int unsigned REG_RXDATA  = 'h0C;
  localparam int unsigned REG_BAUDDIV = 'h10;

  // CTRL bits
  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_RX_EN  = 1;
  localparam int unsigned CTRL_TX_RST = 2;
  localparam int unsigned CTRL_RX_RST = 3;
  localparam int unsigned CTRL_IE_RX  = 4;
  localparam int unsigned CTRL_IE_TX  = 5;

  // STATUS bits
  localparam int unsigned ST_TX_BUSY  = 0;
  localparam int unsigned ST_TXH_FULL = 1;
  localparam int unsigned ST_RX_VALID = 2;
  localparam int unsigned ST_RX_OVR   = 3;
  localparam int unsigned ST_RX_BUSY  = 4;

  // 115200 baud from a 100 MHz PCLK
  localparam int unsigned BAUD_DIV_RST = 868;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } tx_state_e;

endpackage

// File: rtl/apb_uart_regs_if.sv
// APB3 bus bundle between the CPU-side master and the UART register slave.
interface apb_uart_regs_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_tx_launch.sv
// TX holding register plus the IDLE/SEND/GAP FSM that hands one byte at a time to the UART.
module uart_tx_launch
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,      // accepted TXDATA write (only when holding reg is empty)
  input  logic [7:0] wr_data,
  input  logic       tx_enable,  // CTRL.TX_EN
  input  logic       clr,        // TX_RST write
  input  logic       tx_done,
  output logic       txh_full,
  output logic       tx_idle,
  output logic       tx_en,
  output logic [7:0] tx_data
);

  tx_state_e  state_q;
  logic [7:0] hold_q;

  // Launch FSM with registered UART outputs; wr_en and a launch never coincide since
  // a write needs an empty holding reg and a launch needs a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      txh_full <= 1'b0;
      tx_en    <= 1'b0;
      tx_data  <= '0;
    end else if (clr) begin
      state_q  <= StIdle;
      txh_full <= 1'b0;
      tx_en    <= 1'b0;
    end else begin
      if (wr_en) begin
        hold_q   <= wr_data;
        txh_full <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (txh_full && tx_enable) begin
            state_q  <= StSend;
            tx_data  <= hold_q;
            tx_en    <= 1'b1;
            txh_full <= 1'b0;
          end
        end
        StSend: begin
          if (tx_done) begin
            state_q <= StGap;
            tx_en   <= 1'b0;
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_idle = (state_q == StIdle);

endmodule

// File: rtl/apb_uart_regs.sv
// APB3 register front-end for FULL_UART: decode, RX capture, baud divider and level interrupt.
module apb_uart_regs #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned BAUD_W       = 20,
  parameter int unsigned BAUD_DIV_RST = uart_pkg::BAUD_DIV_RST
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_uart_regs_if.slave    apb,
  output logic [BAUD_W-1:0] baud_div,
  output logic              uart_tx_en,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_rst,
  output logic              uart_rx_en,
  output logic              uart_rx_rst,
  input  logic              uart_tx_busy,
  input  logic              uart_tx_done,
  input  logic              uart_rx_busy,
  input  logic              uart_rx_done,
  input  logic [7:0]        uart_rx_data,
  output logic              irq
);
  import uart_pkg::*;

  logic              access, rd;
  logic [ADDR_W-1:0] addr;
  logic              sel_ctrl, sel_status, sel_tx, sel_rx, sel_baud, mapped, err, wr_ok;
  logic              tx_en_q, rx_en_q, ie_rx_q, ie_tx_q;
  logic              tx_rst_q, rx_rst_q;
  logic              rx_valid_q, rx_ovr_q, rx_done_q;
  logic [7:0]        rx_data_q;
  logic [BAUD_W-1:0] baud_div_q;
  logic              irq_q;
  logic              txh_full, tx_idle, tx_clr, rx_clr, rx_rise, rx_rd;
  logic [31:0]       rdata;

  assign access = apb.PSEL & apb.PENABLE;
  assign rd     = access & ~apb.PWRITE;
  assign addr   = {apb.PADDR[ADDR_W-1:2], 2'b00};

  assign sel_ctrl   = (addr == ADDR_W'(REG_CTRL));
  assign sel_status = (addr == ADDR_W'(REG_STATUS));
  assign sel_tx     = (addr == ADDR_W'(REG_TXDATA));
  assign sel_rx     = (addr == ADDR_W'(REG_RXDATA));
  assign sel_baud   = (addr == ADDR_W'(REG_BAUDDIV));
  assign mapped     = sel_ctrl | sel_status | sel_tx | sel_rx | sel_baud;

  // Refused accesses leave all state untouched
  assign err   = access & (~mapped | (apb.PWRITE & ((sel_tx & txh_full) | sel_rx)));
  assign wr_ok = access & apb.PWRITE & ~err;

  assign tx_clr  = wr_ok & sel_ctrl & apb.PWDATA[CTRL_TX_RST];
  assign rx_clr  = wr_ok & sel_ctrl & apb.PWDATA[CTRL_RX_RST];
  assign rx_rise = uart_rx_done & ~rx_done_q;
  assign rx_rd   = rd & sel_rx;

  // CTRL, BAUDDIV and the self-clearing reset pulses
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      ie_rx_q    <= 1'b0;
      ie_tx_q    <= 1'b0;
      tx_rst_q   <= 1'b0;
      rx_rst_q   <= 1'b0;
      baud_div_q <= BAUD_W'(BAUD_DIV_RST);
    end else begin
      tx_rst_q <= tx_clr;
      rx_rst_q <= rx_clr;
      if (wr_ok && sel_ctrl) begin
        tx_en_q <= apb.PWDATA[CTRL_TX_EN];
        rx_en_q <= apb.PWDATA[CTRL_RX_EN];
        ie_rx_q <= apb.PWDATA[CTRL_IE_RX];
        ie_tx_q <= apb.PWDATA[CTRL_IE_TX];
      end
      if (wr_ok && sel_baud) begin
        baud_div_q <= apb.PWDATA[BAUD_W-1:0];
      end
    end
  end

  // RX capture: a read racing a new byte hands out the old one and keeps the new one valid
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_done_q <= uart_rx_done;
      if (rx_clr) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end else begin
        if (wr_ok && sel_status && apb.PWDATA[ST_RX_OVR]) begin
          rx_ovr_q <= 1'b0;
        end
        if (rx_rise) begin
          if (!rx_valid_q || rx_rd) begin
            rx_data_q  <= uart_rx_data;
            rx_valid_q <= 1'b1;
          end else begin
            rx_ovr_q <= 1'b1;
          end
        end else if (rx_rd) begin
          rx_valid_q <= 1'b0;
        end
      end
    end
  end

  // Level interrupt, registered
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (ie_rx_q & rx_valid_q) | (ie_tx_q & ~txh_full & tx_idle) | rx_ovr_q;
    end
  end

  uart_tx_launch u_tx_launch (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .wr_en     (wr_ok & sel_tx),
    .wr_data   (apb.PWDATA[7:0]),
    .tx_enable (tx_en_q),
    .clr       (tx_clr),
    .tx_done   (uart_tx_done),
    .txh_full  (txh_full),
    .tx_idle   (tx_idle),
    .tx_en     (uart_tx_en),
    .tx_data   (uart_tx_data)
  );

  // Read mux, driven only during a read access phase
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_ctrl) begin
        rdata[CTRL_TX_EN] = tx_en_q;
        rdata[CTRL_RX_EN] = rx_en_q;
        rdata[CTRL_IE_RX] = ie_rx_q;
        rdata[CTRL_IE_TX] = ie_tx_q;
      end else if (sel_status) begin
        rdata[ST_TX_BUSY]  = uart_tx_busy;
        rdata[ST_TXH_FULL] = txh_full;
        rdata[ST_RX_VALID] = rx_valid_q;
        rdata[ST_RX_OVR]   = rx_ovr_q;
        rdata[ST_RX_BUSY]  = uart_rx_busy;
      end else if (sel_rx) begin
        rdata[7:0] = rx_data_q;
      end else if (sel_baud) begin
        rdata = 32'(baud_div_q);
      end
    end
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;

  assign baud_div    = baud_div_q;
  assign uart_rx_en  = rx_en_q;
  assign uart_tx_rst = tx_rst_q;
  assign uart_rx_rst = rx_rst_q;
  assign irq         = irq_q;

  logic unused_bits;
  assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:BAUD_W]};

endmodule
